// File: rtl/scmp_regs_wb.sv
// rtl/scmp_regs_wb.sv - SC/MP write-back stage: AC/E/SR registers, serial I/O shift and DLY timer
module scmp_regs_wb #(
  parameter int DLY_BASE = 13,
  parameter int DLY_CW   = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wb_valid,
  output logic       wb_ready,
  input  logic [1:0] wb_sel,
  input  logic       wb_flags,
  input  logic [7:0] alu_res,
  input  logic       alu_cy,
  input  logic       alu_ov,
  input  logic       sio_stb,
  input  logic       sin,
  output logic       sout,
  input  logic       sa_i,
  input  logic       sb_i,
  input  logic       dly_start,
  input  logic [7:0] dly_disp,
  output logic       dly_busy,
  output logic       dly_done,
  output logic [7:0] ac_o,
  output logic [7:0] e_o,
  output logic [7:0] sr_o,
  output logic       cy_o,
  output logic       ov_o,
  output logic       ie_o,
  output logic [2:0] flag_o
);

  typedef enum logic {S_IDLE, S_RUN} dly_state_t;

  localparam logic [DLY_CW-1:0] C_DISP_MUL = DLY_CW'(514);
  localparam logic [DLY_CW-1:0] C_BASE     = DLY_CW'(DLY_BASE);

  dly_state_t        r_state;
  logic [DLY_CW-1:0] r_cnt;
  logic              r_done;
  logic [7:0]        r_ac;
  logic [7:0]        r_e;
  logic              r_sout;
  logic              r_cy;
  logic              r_ov;
  logic              r_ie;
  logic [2:0]        r_f;

  logic              w_busy;
  logic              w_wb_acc;
  logic [DLY_CW-1:0] w_dly_n;

  assign w_busy   = (r_state == S_RUN);
  assign w_wb_acc = wb_valid && !w_busy;

  // Total delay length; AC here is the value before any same-cycle write
  assign w_dly_n = C_BASE
                 + {{(DLY_CW-9){1'b0}}, r_ac, 1'b0}
                 + ({{(DLY_CW-8){1'b0}}, dly_disp} * C_DISP_MUL);

  // AC register and DLY sequencer; DLY completion is the only non-ALU AC source
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_ac    <= 8'h00;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_wb_acc && wb_sel == 2'b00) r_ac <= alu_res;
          if (dly_start) begin
            r_cnt   <= w_dly_n - DLY_CW'(1);
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_cnt == '0) begin
            r_ac    <= 8'hFF;
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - DLY_CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // E register and serial shifter; an accepted E write overrides the shifted value
  always_ff @(posedge clk) begin
    if (rst) begin
      r_e    <= 8'h00;
      r_sout <= 1'b0;
    end else begin
      if (sio_stb) begin
        r_e    <= {sin, r_e[7:1]};
        r_sout <= r_e[0];
      end
      if (w_wb_acc && wb_sel == 2'b01) r_e <= alu_res;
    end
  end

  // Stored status bits; a direct SR write takes priority over the flag update
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cy <= 1'b0;
      r_ov <= 1'b0;
      r_ie <= 1'b0;
      r_f  <= 3'b000;
    end else if (w_wb_acc) begin
      if (wb_sel == 2'b10) begin
        r_cy <= alu_res[7];
        r_ov <= alu_res[6];
        r_ie <= alu_res[3];
        r_f  <= alu_res[2:0];
      end else if (wb_flags) begin
        r_cy <= alu_cy;
        r_ov <= alu_ov;
      end
    end
  end

  assign wb_ready = !w_busy;
  assign dly_busy = w_busy;
  assign dly_done = r_done;
  assign sout     = r_sout;
  assign ac_o     = r_ac;
  assign e_o      = r_e;
  assign sr_o     = {r_cy, r_ov, sb_i, sa_i, r_ie, r_f};
  assign cy_o     = r_cy;
  assign ov_o     = r_ov;
  assign ie_o     = r_ie;
  assign flag_o   = r_f;

endmodule

// File: doc/scmp_regs_wb.md
Name: scmp_regs_wb

Overview:
- Write-back stage directly downstream of the SC/MP ALU.
- Holds the architectural AC, E (extension) and SR (status) registers, and captures ALU result, carry and overflow.
- Implements serial I/O shifting of E and the multi-cycle DLY timer, which ends by loading AC with 0xFF.
- Feeds AC/E/CY/OV back to the ALU operand and carry-in inputs.

Parameters:
DLY_BASE, 13, fixed DLY overhead in clocks
DLY_CW, 18, DLY counter width; must hold 13+2*255+514*255

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
wb_valid  in  1  ALU result present this cycle
wb_ready  out  1  = !dly_busy; write accepted when wb_valid&&wb_ready
wb_sel  in  2  00=AC, 01=E, 10=SR, 11=flags only
wb_flags  in  1  also load CY/OV from alu_cy/alu_ov
alu_res  in  8  ALU result
alu_cy  in  1  ALU carry out
alu_ov  in  1  ALU overflow out
sio_stb  in  1  shift E right one bit
sin  in  1  serial in, enters E[7]
sout  out  1  registered serial out, E[0] captured at the shift
sa_i  in  1  sense A pin, synchronised externally
sb_i  in  1  sense B pin
dly_start  in  1  start DLY
dly_disp  in  8  DLY displacement operand
dly_busy  out  1  DLY in progress
dly_done  out  1  one-cycle pulse at DLY completion
ac_o  out  8  accumulator
e_o  out  8  extension register
sr_o  out  8  {CY,OV,SB,SA,IE,F2,F1,F0}
cy_o  out  1  = SR[7], to ALU Cy_i
ov_o  out  1  = SR[6], to ALU Ov_i
ie_o  out  1  = SR[3]
flag_o  out  3  = SR[2:0]

Behaviour:
- Reset (rst high at edge):
  - AC=0, E=0, SR stored bits 7,6,3:0 = 0, sout=0, dly_busy=0, dly_done=0, counter=0.
  - Reset mid-DLY aborts with no done pulse.
- SR[5:4] are not stored: combinationally {sb_i, sa_i}. Writes to these bits are ignored.
- Accepted write (wb_valid && wb_ready): updates at that edge; visible on outputs the next cycle, i.e. 1-cycle latency.
  - sel 00: AC<=alu_res.
  - sel 01: E<=alu_res.
  - sel 10: SR[7:6,3:0]<=alu_res[7:6,3:0].
  - sel 11: no data register written.
  - wb_flags=1: CY<=alu_cy, OV<=alu_ov. Exception: with sel 10, the SR write wins for CY/OV.
- wb_valid while dly_busy: not accepted, no state change. Upstream holds the request.
- SIO: on sio_stb, E<={sin,E[7:1]} and sout<=E[0]. sout otherwise holds its value.
  - Same edge as an accepted E write (sel 01): the write wins for E; sout<=E[0] still updates.
  - sio_stb is honoured during DLY.
- DLY timer:
  - States: IDLE, RUN.
  - IDLE, dly_start && !dly_busy: N = DLY_BASE + 2*AC + 514*dly_disp, computed at DLY_CW bits with no overflow. counter<=N-1, go to RUN.
  - dly_start and wb_valid in the same IDLE cycle: the write is accepted. N uses the pre-write AC.
  - RUN: dly_busy=1, counter decrements each clock.
  - RUN with counter==0: at that edge AC<=0xFF, go to IDLE, dly_done=1 for the following cycle only.
  - dly_busy is high for exactly N cycles, starting the cycle after the start edge.
  - dly_start during RUN is ignored.
  - CY/OV/E/SR are unchanged by DLY.
- cy_o/ov_o/ie_o/flag_o/ac_o/e_o are direct register outputs, with no combinational path from the wb inputs.

Test Plan:
- Reset, then wb AC alu_res=0x5A, wb_flags=1, cy=1, ov=0 -> next cycle ac_o=0x5A, sr_o[7:6]=2'b10, e_o=0x00.
- wb SR alu_res=0xFF with sa_i=0, sb_i=1, then wb_flags=1 cy=0 on sel 10 -> sr_o=0xEF; CY/OV stay 1 (SR write wins).
- E=0x81, eight sio_stb pulses with sin=1,0,1,0,1,0,1,0 -> sout sequence 1,0,0,0,0,0,0,1; final E=0x55. Same-cycle E write 0x3C + sio_stb -> E=0x3C, sout=prior E[0].
- AC=0x00, dly_disp=0, dly_start -> dly_busy high exactly 13 cycles, wb_ready low throughout, then dly_done one cycle and ac_o=0xFF.
- AC=0x10, dly_disp=0x01 -> busy 559 cycles. AC=0xFF, disp=0xFF -> busy 131593 cycles, no counter wrap.
- rst asserted at cycle 100 of a 559-cycle DLY -> next cycle busy=0, ac_o=0x00, no dly_done pulse. wb_valid during busy leaves AC unchanged.
